id_issue_ctrl: RTL and testbench

Issue controller between the fetch stage and the decoder. Buffers fetched instructions in a small FIFO and tracks in-flight register writes with a 32-entry scoreboard. Releases the head instruction to the decoder/execute path only when it has no RAW or WAW hazard. Also handles pipeline flushes and counts hazard stall cycles.

---
 rtl/riscv_pkg.sv | 49 ++++
 rtl/id_issue_ctrl_instr_fifo.sv | 52 +++++
 rtl/id_issue_ctrl.sv | 101 ++++++++++
 tb/tb_id_issue_ctrl.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared RISC-V decode constants, the fetch entry type and opcode-class helpers
// used by the issue controller.
package riscv_pkg;

    localparam logic [4:0] OP_LOAD     = 5'b00000;
    localparam logic [4:0] OP_MISC_MEM = 5'b00011;
    localparam logic [4:0] OP_ALU_IMM  = 5'b00100;
    localparam logic [4:0] OP_AUIPC    = 5'b00101;
    localparam logic [4:0] OP_STORE    = 5'b01000;
    localparam logic [4:0] OP_ALU      = 5'b01100;
    localparam logic [4:0] OP_LUI      = 5'b01101;
    localparam logic [4:0] OP_BRANCH   = 5'b11000;
    localparam logic [4:0] OP_JALR     = 5'b11001;
    localparam logic [4:0] OP_JAL      = 5'b11011;
    localparam logic [4:0] OP_SYSTEM   = 5'b11100;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
    } fetch_entry_t;

    function automatic logic writes_rd(input logic [4:0] opcode);
        case (opcode)
            OP_ALU, OP_ALU_IMM, OP_LOAD, OP_JALR,
            OP_LUI, OP_AUIPC, OP_JAL:               return 1'b1;
            default:                                return 1'b0;
        endcase
    endfunction

    function automatic logic reads_rs1(input logic [4:0] opcode);
        case (opcode)
            OP_ALU, OP_ALU_IMM, OP_LOAD, OP_JALR,
            OP_STORE, OP_BRANCH:                    return 1'b1;
            default:                                return 1'b0;
        endcase
    endfunction

    function automatic logic reads_rs2(input logic [4:0] opcode);
        case (opcode)
            OP_ALU, OP_STORE, OP_BRANCH:            return 1'b1;
            default:                                return 1'b0;
        endcase
    endfunction

    function automatic logic [31:0] onehot(input logic [4:0] idx);
        return 32'h0000_0001 << idx;
    endfunction

endpackage

// File: rtl/id_issue_ctrl_instr_fifo.sv
// Small instruction FIFO with wrap-bit pointers; the head is read straight out
// of registered storage so there is no fetch-to-issue combinational path.
module instr_fifo
    import riscv_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         push_i,
    input  fetch_entry_t entry_i,
    input  logic         pop_i,
    input  logic         flush_i,
    output fetch_entry_t head_o,
    output logic         full_o,
    output logic         empty_o
);

    localparam int AW = $clog2(DEPTH);

    fetch_entry_t mem_r [DEPTH];
    logic [AW:0]  wr_ptr_r;
    logic [AW:0]  rd_ptr_r;

    assign empty_o = (wr_ptr_r == rd_ptr_r);
    assign full_o  = (wr_ptr_r[AW] != rd_ptr_r[AW]) &&
                     (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
    assign head_o  = mem_r[rd_ptr_r[AW-1:0]];

    // Pointer and storage update; flush wins over push and pop.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= '0;
            end
        end else if (flush_i) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
        end else begin
            if (push_i && !full_o) begin
                mem_r[wr_ptr_r[AW-1:0]] <= entry_i;
                wr_ptr_r <= wr_ptr_r + {{AW{1'b0}}, 1'b1};
            end
            if (pop_i && !empty_o) begin
                rd_ptr_r <= rd_ptr_r + {{AW{1'b0}}, 1'b1};
            end
        end
    end

endmodule

// File: rtl/id_issue_ctrl.sv
// Issue controller: buffers fetched instructions, blocks the head on RAW/WAW
// hazards against a 32-entry scoreboard and counts hazard stall cycles.
module id_issue_ctrl
    import riscv_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int CNT_W = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             fetch_valid_i,
    input  logic [31:0]      fetch_instr_i,
    input  logic [31:0]      fetch_pc_i,
    output logic             fetch_ready_o,
    output logic             issue_valid_o,
    output logic [31:0]      issue_instr_o,
    output logic [31:0]      issue_pc_o,
    input  logic             issue_ready_i,
    input  logic             wb_valid_i,
    input  logic [4:0]       wb_rd_i,
    input  logic             flush_i,
    output logic [CNT_W-1:0] stall_cnt_o
);

    fetch_entry_t     head_s;
    fetch_entry_t     entry_s;
    logic             full_s;
    logic             empty_s;
    logic [4:0]       opc_s;
    logic [4:0]       rd_s;
    logic [4:0]       rs1_s;
    logic [4:0]       rs2_s;
    logic [31:0]      sb_r;
    logic [31:0]      sb_eff_s;
    logic [31:0]      sb_set_s;
    logic             hazard_s;
    logic             issue_fire_s;
    logic             fetch_fire_s;
    logic [CNT_W-1:0] stall_cnt_r;

    assign entry_s       = '{instr: fetch_instr_i, pc: fetch_pc_i};
    assign fetch_ready_o = !full_s && !rst_i;
    assign fetch_fire_s  = fetch_valid_i && fetch_ready_o;
    assign issue_fire_s  = issue_valid_o && issue_ready_i;

    instr_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (fetch_fire_s),
        .entry_i (entry_s),
        .pop_i   (issue_fire_s),
        .flush_i (flush_i),
        .head_o  (head_s),
        .full_o  (full_s),
        .empty_o (empty_s)
    );

    assign opc_s = head_s.instr[6:2];
    assign rd_s  = head_s.instr[11:7];
    assign rs1_s = head_s.instr[19:15];
    assign rs2_s = head_s.instr[24:20];

    // Writeback clears its bit before the check so a dependent head issues that same cycle.
    always_comb begin
        sb_eff_s = sb_r & ~(wb_valid_i ? onehot(wb_rd_i) : 32'h0000_0000);
        hazard_s = (reads_rs1(opc_s) && (rs1_s != 5'd0) && sb_eff_s[rs1_s]) ||
                   (reads_rs2(opc_s) && (rs2_s != 5'd0) && sb_eff_s[rs2_s]) ||
                   (writes_rd(opc_s) && (rd_s  != 5'd0) && sb_eff_s[rd_s]);
        if (issue_fire_s && writes_rd(opc_s) && (rd_s != 5'd0)) begin
            sb_set_s = onehot(rd_s);
        end else begin
            sb_set_s = 32'h0000_0000;
        end
    end

    assign issue_valid_o = !empty_s && !hazard_s && !flush_i;
    assign issue_instr_o = head_s.instr;
    assign issue_pc_o    = head_s.pc;
    assign stall_cnt_o   = stall_cnt_r;

    // Scoreboard survives flushes because in-flight writes still retire.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sb_r <= 32'h0000_0000;
        end else begin
            sb_r <= sb_eff_s | sb_set_s;
        end
    end

    // Saturating hazard stall counter.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            stall_cnt_r <= '0;
        end else if (!empty_s && hazard_s && !flush_i && (stall_cnt_r != {CNT_W{1'b1}})) begin
            stall_cnt_r <= stall_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            stall_cnt_r <= stall_cnt_r;
        end
    end

endmodule

// File: tb/tb_id_issue_ctrl.sv
// Directed plus randomized bench for id_issue_ctrl, checked against a queue-based
// reference model of the issue rules.
module tb_id_issue_ctrl;

    localparam int DEPTH = 2;
    localparam int CNT_W = 16;
    localparam int unsigned STALL_MAX = (1 << CNT_W) - 1;

    logic        clk = 1'b0;
    logic        rst;
    logic        fetch_valid;
    logic [31:0] fetch_instr;
    logic [31:0] fetch_pc;
    logic        fetch_ready;
    logic        issue_valid;
    logic [31:0] issue_instr;
    logic [31:0] issue_pc;
    logic        issue_ready;
    logic        wb_valid;
    logic [4:0]  wb_rd;
    logic        flush;
    logic [CNT_W-1:0] stall_cnt;

    int checks = 0;
    int failures = 0;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc;
    } ent_t;

    ent_t        q[$];
    logic [31:0] pend_m;
    int unsigned stall_m;
    logic [31:0] pc_seq = 32'h0000_1000;

    always #5 clk = ~clk;

    id_issue_ctrl #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .fetch_valid_i (fetch_valid),
        .fetch_instr_i (fetch_instr),
        .fetch_pc_i    (fetch_pc),
        .fetch_ready_o (fetch_ready),
        .issue_valid_o (issue_valid),
        .issue_instr_o (issue_instr),
        .issue_pc_o    (issue_pc),
        .issue_ready_i (issue_ready),
        .wb_valid_i    (wb_valid),
        .wb_rd_i       (wb_rd),
        .flush_i       (flush),
        .stall_cnt_o   (stall_cnt)
    );

    function automatic logic [31:0] mk(input logic [4:0] op, input logic [4:0] rd,
                                       input logic [4:0] rs1, input logic [4:0] rs2);
        return {7'b0000000, rs2, rs1, 3'b000, rd, op, 2'b11};
    endfunction

    function automatic bit m_writes(input logic [4:0] op);
        return op inside {5'b01100, 5'b00100, 5'b00000, 5'b11001, 5'b01101, 5'b00101, 5'b11011};
    endfunction

    function automatic bit m_reads1(input logic [4:0] op);
        return op inside {5'b01100, 5'b00100, 5'b00000, 5'b11001, 5'b01000, 5'b11000};
    endfunction

    function automatic bit m_reads2(input logic [4:0] op);
        return op inside {5'b01100, 5'b01000, 5'b11000};
    endfunction

    function automatic bit m_hazard(input logic [31:0] ins, input bit wbv, input logic [4:0] wbrd);
        bit busy [32];
        for (int i = 0; i < 32; i++) busy[i] = pend_m[i];
        if (wbv) busy[wbrd] = 1'b0;
        busy[0] = 1'b0;
        return (m_reads1(ins[6:2]) && busy[ins[19:15]]) ||
               (m_reads2(ins[6:2]) && busy[ins[24:20]]) ||
               (m_writes(ins[6:2]) && busy[ins[11:7]]);
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One cycle: drive at the falling edge, check, then advance the model at the rising edge.
    task automatic step(input bit fv, input logic [31:0] ins, input bit ir,
                        input bit wbv, input logic [4:0] wbrd, input bit fl);
        bit   exp_r, exp_v, hz, nonempty, popped;
        ent_t h;
        fetch_valid = fv;
        fetch_instr = ins;
        fetch_pc    = pc_seq;
        issue_ready = ir;
        wb_valid    = wbv;
        wb_rd       = wbrd;
        flush       = fl;
        #1;
        nonempty = (q.size() > 0);
        exp_r    = (q.size() < DEPTH);
        hz       = nonempty && m_hazard(q[0].instr, wbv, wbrd);
        exp_v    = nonempty && !hz && !fl;
        chk("fetch_ready", {63'd0, fetch_ready}, {63'd0, exp_r});
        chk("issue_valid", {63'd0, issue_valid}, {63'd0, exp_v});
        chk("stall_cnt", {48'd0, stall_cnt}, {32'd0, stall_m});
        chk("scoreboard", {32'd0, dut.sb_r}, {32'd0, pend_m});
        if (nonempty) begin
            chk("issue_instr", {32'd0, issue_instr}, {32'd0, q[0].instr});
            chk("issue_pc", {32'd0, issue_pc}, {32'd0, q[0].pc});
        end
        @(posedge clk);
        popped = 1'b0;
        if (fl) begin
            q.delete();
        end else begin
            if (exp_v && ir) begin
                h = q.pop_front();
                popped = 1'b1;
            end
            if (fv && exp_r) q.push_back('{instr: ins, pc: pc_seq});
        end
        if (fv && exp_r) pc_seq = pc_seq + 32'd4;
        if (wbv) pend_m[wbrd] = 1'b0;
        if (popped && m_writes(h.instr[6:2]) && (h.instr[11:7] != 5'd0))
            pend_m[h.instr[11:7]] = 1'b1;
        if (nonempty && hz && !fl && (stall_m < STALL_MAX)) stall_m++;
        @(negedge clk);
    endtask

    task automatic idle(input bit ir);
        step(1'b0, 32'h0, ir, 1'b0, 5'd0, 1'b0);
    endtask

    task automatic wb(input logic [4:0] r);
        step(1'b0, 32'h0, 1'b0, 1'b1, r, 1'b0);
    endtask

    logic [4:0] ops [12] = '{5'b00000, 5'b00011, 5'b00100, 5'b00101, 5'b01000, 5'b01100,
                             5'b01101, 5'b11000, 5'b11001, 5'b11011, 5'b11100, 5'b11111};

    initial begin
        rst = 1'b1;
        fetch_valid = 1'b0; fetch_instr = 32'h0; fetch_pc = 32'h0;
        issue_ready = 1'b0; wb_valid = 1'b0; wb_rd = 5'd0; flush = 1'b0;
        q.delete(); pend_m = 32'h0; stall_m = 0;
        #3;
        chk("rst_fetch_ready", {63'd0, fetch_ready}, 64'd0);
        chk("rst_issue_valid", {63'd0, issue_valid}, 64'd0);
        chk("rst_stall", {48'd0, stall_cnt}, 64'd0);
        chk("rst_instr", {32'd0, issue_instr}, 64'd0);
        chk("rst_pc", {32'd0, issue_pc}, 64'd0);
        @(negedge clk);
        rst = 1'b0;

        // Back-to-back independent instructions
        step(1'b1, 32'h0010_0093, 1'b1, 1'b0, 5'd0, 1'b0);
        step(1'b1, 32'h0020_0113, 1'b1, 1'b0, 5'd0, 1'b0);
        idle(1'b1);
        idle(1'b1);
        chk("sb_b2b", {32'd0, dut.sb_r}, 64'h6);
        chk("stall_b2b", {48'd0, stall_cnt}, 64'd0);

        // RAW on x1, released by a same-cycle writeback
        wb(5'd2);
        step(1'b1, 32'h0010_81B3, 1'b1, 1'b0, 5'd0, 1'b0);
        repeat (3) idle(1'b1);
        step(1'b0, 32'h0, 1'b1, 1'b1, 5'd1, 1'b0);
        idle(1'b1);
        chk("sb_raw", {32'd0, dut.sb_r}, 64'h8);
        chk("stall_raw", {48'd0, stall_cnt}, 64'd3);

        // WAW on x5, then x0 writes never tracked
        wb(5'd3);
        step(1'b1, mk(5'b00100, 5'd5, 5'd0, 5'd0), 1'b1, 1'b0, 5'd0, 1'b0);
        idle(1'b1);
        step(1'b1, mk(5'b01101, 5'd5, 5'd0, 5'd0), 1'b1, 1'b0, 5'd0, 1'b0);
        repeat (2) idle(1'b1);
        step(1'b0, 32'h0, 1'b1, 1'b1, 5'd5, 1'b0);
        step(1'b1, 32'h0000_0013, 1'b1, 1'b0, 5'd0, 1'b0);
        step(1'b1, 32'h0000_0013, 1'b1, 1'b0, 5'd0, 1'b0);
        idle(1'b1);
        wb(5'd5);
        chk("sb_x0", {32'd0, dut.sb_r}, 64'h0);

        // Full FIFO, push+pop at PARTIAL, wrap ordering over 10 entries
        for (int i = 0; i < DEPTH + 1; i++)
            step(1'b1, mk(5'b00100, 5'(10 + i), 5'd0, 5'd0), 1'b0, 1'b0, 5'd0, 1'b0);
        step(1'b1, mk(5'b00100, 5'd20, 5'd0, 5'd0), 1'b1, 1'b0, 5'd0, 1'b0);
        step(1'b1, mk(5'b00100, 5'd21, 5'd0, 5'd0), 1'b1, 1'b0, 5'd0, 1'b0);
        for (int i = 0; i < 10; i++)
            step(1'b1, mk(5'b01000, 5'd0, 5'd0, 5'd0) | 32'(i << 25), (i % 3) != 0, 1'b0, 5'd0, 1'b0);
        repeat (4) idle(1'b1);
        for (int r = 10; r < 22; r++) wb(5'(r));

        // Flush with a pending x7 write
        step(1'b1, mk(5'b00100, 5'd7, 5'd0, 5'd0), 1'b1, 1'b0, 5'd0, 1'b0);
        idle(1'b1);
        step(1'b1, mk(5'b00100, 5'd8, 5'd0, 5'd0), 1'b0, 1'b0, 5'd0, 1'b0);
        step(1'b1, mk(5'b00100, 5'd9, 5'd0, 5'd0), 1'b0, 1'b0, 5'd0, 1'b0);
        step(1'b1, mk(5'b00100, 5'd10, 5'd0, 5'd0), 1'b1, 1'b0, 5'd0, 1'b1);
        idle(1'b0);
        chk("flush_empty_valid", {63'd0, issue_valid}, 64'd0);
        chk("flush_sb7", {63'd0, dut.sb_r[7]}, 64'd1);
        wb(5'd7);

        // Randomized traffic against the model
        for (int n = 0; n < 3000; n++) begin
            logic [4:0] r;
            r = 5'($urandom_range(0, 7));
            step($urandom_range(0, 3) != 0,
                 mk(ops[$urandom_range(0, 11)], 5'($urandom_range(0, 7)),
                    5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))),
                 $urandom_range(0, 2) != 0, $urandom_range(0, 1) == 1, r,
                 $urandom_range(0, 29) == 0);
        end
        step(1'b0, 32'h0, 1'b0, 1'b0, 5'd0, 1'b1);
        for (int r = 1; r < 32; r++) wb(5'(r));

        // Saturation of the stall counter
        step(1'b1, 32'h0010_0093, 1'b1, 1'b0, 5'd0, 1'b0);
        step(1'b1, 32'h0010_81B3, 1'b1, 1'b0, 5'd0, 1'b0);
        for (int n = 0; n < (1 << CNT_W) + 4; n++) idle(1'b1);
        chk("stall_sat", {48'd0, stall_cnt}, 64'hFFFF);

        // Asynchronous reset mid-stream with sb = 0xFE
        step(1'b0, 32'h0, 1'b0, 1'b0, 5'd0, 1'b1);
        for (int i = 2; i < 8; i++)
            step(1'b1, mk(5'b00100, 5'(i), 5'd0, 5'd0), 1'b1, 1'b0, 5'd0, 1'b0);
        idle(1'b1);
        chk("sb_pre_rst", {32'd0, dut.sb_r}, 64'hFE);
        step(1'b1, mk(5'b00100, 5'd9, 5'd0, 5'd0), 1'b0, 1'b0, 5'd0, 1'b0);
        step(1'b1, mk(5'b00100, 5'd10, 5'd0, 5'd0), 1'b0, 1'b0, 5'd0, 1'b0);
        fetch_valid = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        chk("arst_fetch_ready", {63'd0, fetch_ready}, 64'd0);
        chk("arst_issue_valid", {63'd0, issue_valid}, 64'd0);
        chk("arst_instr", {32'd0, issue_instr}, 64'd0);
        chk("arst_pc", {32'd0, issue_pc}, 64'd0);
        chk("arst_stall", {48'd0, stall_cnt}, 64'd0);
        chk("arst_sb", {32'd0, dut.sb_r}, 64'd0);
        @(negedge clk);
        rst = 1'b0;
        q.delete(); pend_m = 32'h0; stall_m = 0;
        step(1'b1, 32'h0010_0093, 1'b1, 1'b0, 5'd0, 1'b0);
        idle(1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
